// File: rtl/gap_cls_pkg.sv
// Shared definitions for the classifier back end.
//   - FP32 field masks used by the ordering comparator
//   - default class count
//   - scan FSM state encoding
//   - fp_is_nan: true for exp==all-ones with a non-zero mantissa
package gap_cls_pkg;

  localparam logic [31:0] SIGN_MASK = 32'h8000_0000;
  localparam logic [31:0] EXP_MASK  = 32'h7F80_0000;
  localparam logic [31:0] MANT_MASK = 32'h007F_FFFF;

  localparam int NUM_CLASS_DEF = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return ((x & EXP_MASK) == EXP_MASK) && ((x & MANT_MASK) != 32'h0);
  endfunction

endpackage

// File: rtl/fp32_cmp_gt.sv
// Combinational FP32 "strictly greater" compare with a total ordering.
//   a, b   : raw IEEE-754 single-precision bits
//   a_gt_b : 1 when a ranks strictly above b
// Ordering: NaN ranks below -inf (and NaN never beats NaN), -0 equals +0,
// everything else follows the sign-folded unsigned key so denormals and
// infinities need no special handling.
module fp32_cmp_gt
  import gap_cls_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic        a_nan, b_nan;
  logic [31:0] a_n, b_n, key_a, key_b;

  assign a_nan = fp_is_nan(a);
  assign b_nan = fp_is_nan(b);

  // Fold -0 onto +0 so the two compare equal.
  assign a_n = (a == SIGN_MASK) ? 32'h0 : a;
  assign b_n = (b == SIGN_MASK) ? 32'h0 : b;

  // Positive: set the sign bit so positives sit above negatives.
  // Negative: invert so larger magnitude gives a smaller key.
  assign key_a = a_n[31] ? ~a_n : (a_n ^ SIGN_MASK);
  assign key_b = b_n[31] ? ~b_n : (b_n ^ SIGN_MASK);

  always_comb begin
    if (a_nan)      a_gt_b = 1'b0;
    else if (b_nan) a_gt_b = 1'b1;
    else            a_gt_b = (key_a > key_b);
  end

endmodule

// File: rtl/gap_argmax_classifier.sv
// Argmax over the pooled class-score vector.
//   clk, rst  : single clock, synchronous active-high reset
//   Data_In   : NUM_CLASS packed FP32 scores, class k at word k
//   Valid_In  : Data_In valid; accepted only when idle
//   Busy      : scan in progress
//   Class_Out : index of the winning score (held until next result)
//   Max_Out   : raw bits of the winning score (held until next result)
//   Valid_Out : one-cycle result strobe
//   Overrun   : one-cycle strobe, a vector arrived while busy and was dropped
// One compare per clock; result strobes NUM_CLASS-1 edges after capture.
module gap_argmax_classifier
  import gap_cls_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int NUM_CLASS  = NUM_CLASS_DEF,
  parameter int IDX_W      = $clog2(NUM_CLASS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDHT*NUM_CLASS-1:0] Data_In,
  input  logic                            Valid_In,
  output logic                            Busy,
  output logic [IDX_W-1:0]                Class_Out,
  output logic [DATA_WIDHT-1:0]           Max_Out,
  output logic                            Valid_Out,
  output logic                            Overrun
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);

  state_t                               state, state_nxt;
  logic [NUM_CLASS-1:0][DATA_WIDHT-1:0] cap_buf;
  logic [DATA_WIDHT-1:0]                best_val, cur_word, nxt_val;
  logic [IDX_W-1:0]                     best_idx, idx, nxt_idx;
  logic                                 cand_gt, load, done;

  assign Busy     = (state == SCAN);
  assign cur_word = cap_buf[idx];

  fp32_cmp_gt u_cmp (
    .a      (cur_word),
    .b      (best_val),
    .a_gt_b (cand_gt)
  );

  // Strict compare keeps the lowest index on ties.
  assign nxt_val = cand_gt ? cur_word : best_val;
  assign nxt_idx = cand_gt ? idx      : best_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (Valid_In) begin
        load      = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: if (idx == LAST) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_buf   <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      idx       <= '0;
      Class_Out <= '0;
      Max_Out   <= '0;
      Valid_Out <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      Valid_Out <= done;
      Overrun   <= Busy && Valid_In;
      if (load) begin
        cap_buf  <= Data_In;
        best_val <= Data_In[DATA_WIDHT-1:0];
        best_idx <= '0;
        idx      <= IDX_W'(1);
      end else if (Busy) begin
        best_val <= nxt_val;
        best_idx <= nxt_idx;
        idx      <= idx + IDX_W'(1);
        // Final edge publishes the post-compare best directly.
        if (done) begin
          Class_Out <= nxt_idx;
          Max_Out   <= nxt_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_gap_argmax_classifier.sv
module tb_gap_argmax_classifier;

  localparam int NC = 7;

  typedef struct {
    logic [2:0]  cls;
    logic [31:0] max;
    int          cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*32-1:0]  Data_In;
  logic              Valid_In;
  logic              Busy;
  logic [2:0]        Class_Out;
  logic [31:0]       Max_Out;
  logic              Valid_Out;
  logic              Overrun;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  gap_argmax_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .Busy      (Busy),
    .Class_Out (Class_Out),
    .Max_Out   (Max_Out),
    .Valid_Out (Valid_Out),
    .Overrun   (Overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NC*32-1:0] mk(input logic [31:0] w0, w1, w2, w3, w4, w5, w6);
    logic [NC-1:0][31:0] v;
    v[0] = w0; v[1] = w1; v[2] = w2; v[3] = w3; v[4] = w4; v[5] = w5; v[6] = w6;
    return v;
  endfunction

  // Monitor: every result strobe must match the oldest expected result,
  // including the cycle in which it appears.
  always @(negedge clk) begin
    if (Valid_Out) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: cls=%0d max=%h cyc=%0d", Class_Out, Max_Out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("class", 32'(Class_Out), 32'(e.cls));
        chk("max", Max_Out, e.max);
        chk("latency_cyc", cyc, e.cyc);
      end
    end
  end

  // Drive at a negedge; the following posedge is E0. Leaves the caller at
  // the negedge just after E0 with Valid_In dropped.
  task automatic send(input logic [NC*32-1:0] v, input bit expect_res,
                      input logic [2:0] ecls, input logic [31:0] emax);
    Data_In  = v;
    Valid_In = 1'b1;
    if (expect_res) sb.push_back('{cls: ecls, max: emax, cyc: cyc + NC});
    @(negedge clk);
    Valid_In = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [NC*32-1:0] vA, vB, v2, v3a, v3b, v3c, v6;
  int busy_cnt;

  initial begin
    vA  = mk(32'h3F800000, 32'h40000000, 32'hC0000000, 32'h3F000000, 32'h40400000, 32'hBF800000, 32'h40200000);
    vB  = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h41000000);
    v2  = mk(32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hC0800000, 32'hC0A00000, 32'hC0C00000, 32'hC0E00000);
    v3a = mk(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000);
    v3b = mk(32'h80000000, 32'h00000000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000);
    v3c = mk(32'h7FC00000, 32'hFF800000, 32'hFF800000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 32'hFF800000);
    v6  = {NC{32'h7FC00001}};

    rst = 1'b1; Valid_In = 1'b0; Data_In = '0;
    idle(2);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_class", 32'(Class_Out), 0);
    chk("rst_max", Max_Out, 0);
    chk("rst_valid", 32'(Valid_Out), 0);
    chk("rst_overrun", 32'(Overrun), 0);
    rst = 1'b0;
    idle(1);

    // Test 1: basic, plus Busy width
    send(vA, 1, 3'd4, 32'h40400000);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (Busy) busy_cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_cnt, 6);
    idle(2);

    // Test 2/3/6: pattern coverage
    send(v2,  1, 3'd1, 32'hBF800000); idle(8);
    send(v3a, 1, 3'd2, 32'h40000000); idle(8);
    send(v3b, 1, 3'd0, 32'h80000000); idle(8);
    send(v3c, 1, 3'd3, 32'h3F800000); idle(8);
    send(v6,  1, 3'd0, 32'h7FC00001); idle(8);

    // Test 4: overrun at E3, then B back-to-back in the Valid_Out cycle
    send(vA, 1, 3'd4, 32'h40400000);
    idle(2);
    Data_In = vB; Valid_In = 1'b1;
    @(negedge clk);
    Valid_In = 1'b0;
    chk("overrun_pulse", 32'(Overrun), 1);
    chk("overrun_busy", 32'(Busy), 1);
    @(negedge clk);
    chk("overrun_one_cycle", 32'(Overrun), 0);
    idle(2);
    chk("b2b_valid_cycle", 32'(Valid_Out), 1);
    send(vB, 1, 3'd6, 32'h41000000);
    idle(8);

    // Test 5: reset mid-scan abandons the scan
    send(vA, 0, 3'd0, 32'h0);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(Busy), 0);
    chk("midrst_class", 32'(Class_Out), 0);
    chk("midrst_max", Max_Out, 0);
    chk("midrst_valid", 32'(Valid_Out), 0);
    idle(1);
    send(v2, 1, 3'd1, 32'hBF800000);
    idle(8);

    // rst and Valid_In together: nothing latched
    rst = 1'b1; Data_In = vA; Valid_In = 1'b1;
    @(negedge clk);
    rst = 1'b0; Valid_In = 1'b0;
    chk("rst_wins_busy", 32'(Busy), 0);
    idle(8);

    chk("pending_results", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
